// File: rtl/pulse_measure.sv
// Pulse width / signed peak measurement behind the trigger detector.
// One record per completed pulse leaves on an AXI-Stream master with a one-entry output register.
module pulse_measure #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    input  logic [WIDTH-1:0]           s_tdata,
    input  logic [1:0]                 s_tuser,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [WIDTH+CNT_WIDTH-1:0] m_tdata,
    output logic                       m_tuser,
    output logic [31:0]                pulse_count
);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_IN_PULSE = 1'b1;

    localparam logic [CNT_WIDTH-1:0] WIDTH_MAX = '1;

    logic [0:0]                 state_q, state_d;
    logic [CNT_WIDTH-1:0]       width_q, width_d;
    logic signed [WIDTH-1:0]    peak_q, peak_d;
    logic                       sat_q, sat_d;
    logic                       mvalid_q, mvalid_d;
    logic [WIDTH+CNT_WIDTH-1:0] mdata_q, mdata_d;
    logic                       muser_q, muser_d;
    logic [31:0]                count_q, count_d;

    logic beat_acc;
    logic out_take;

    // Input only stalls while a record is pending and not being taken this cycle.
    assign s_tready = ~mvalid_q | m_tready;
    assign beat_acc = s_tvalid & s_tready;
    assign out_take = mvalid_q & m_tready;

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        peak_d   = peak_q;
        sat_d    = sat_q;
        mvalid_d = mvalid_q;
        mdata_d  = mdata_q;
        muser_d  = muser_q;
        count_d  = count_q;

        if (out_take) begin
            mvalid_d = 1'b0;
            count_d  = count_q + 32'd1;
        end

        if (beat_acc) begin
            case (state_q)
                ST_IDLE: begin
                    // Rising wins over falling; a lone falling flag is ignored here.
                    if (s_tuser[0] && enable) begin
                        state_d = ST_IN_PULSE;
                        width_d = CNT_WIDTH'(1);
                        peak_d  = $signed(s_tdata);
                        sat_d   = 1'b0;
                    end
                end
                ST_IN_PULSE: begin
                    if (s_tuser[1]) begin
                        // Falling beat closes the pulse and is not part of it.
                        state_d  = ST_IDLE;
                        mdata_d  = {peak_q, width_q};
                        muser_d  = sat_q;
                        mvalid_d = 1'b1;
                    end else begin
                        if (width_q == WIDTH_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            width_d = width_q + 1'b1;
                        end
                        if ($signed(s_tdata) > peak_q) begin
                            peak_d = $signed(s_tdata);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            width_q  <= '0;
            peak_q   <= '0;
            sat_q    <= 1'b0;
            mvalid_q <= 1'b0;
            mdata_q  <= '0;
            muser_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            width_q  <= width_d;
            peak_q   <= peak_d;
            sat_q    <= sat_d;
            mvalid_q <= mvalid_d;
            mdata_q  <= mdata_d;
            muser_q  <= muser_d;
            count_q  <= count_d;
        end
    end

    assign m_tvalid    = mvalid_q;
    assign m_tdata     = mdata_q;
    assign m_tuser     = muser_q;
    assign pulse_count = count_q;

endmodule

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
- Sits directly downstream of the trigger detector and consumes its pass-through sample stream and its trigger flags {falling, rising}.
- Measures each pulse from the rising-crossing beat up to the falling-crossing beat: pulse width in beats and signed peak amplitude.
- Emits one record per completed pulse on an AXI-Stream master toward the histogram/readout logic.
- Keeps a running count of emitted pulses.

Parameters:
- WIDTH, 16, sample width; samples are two's-complement signed.
- CNT_WIDTH, 16, width of the pulse-width counter in the output record.

Ports:
- clk  in  1  single clock; all logic in this domain.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, new pulses are not armed; a pulse already in progress completes normally.
- s_tvalid  in  1  input sample valid.
- s_tready  out  1  input ready.
- s_tdata  in  WIDTH  signed sample.
- s_tuser  in  2  trigger flags: bit0 = rising, bit1 = falling.
- m_tvalid  out  1  record valid.
- m_tready  in  1  record accepted by the consumer.
- m_tdata  out  WIDTH+CNT_WIDTH  record {peak[WIDTH-1:0], width[CNT_WIDTH-1:0]}.
- m_tuser  out  1  set when the width counter saturated for this record.
- pulse_count  out  32  number of records accepted on the master side; wraps modulo 2^32.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting reset forces m_tvalid=0, m_tdata=0, m_tuser=0 and pulse_count=0, and returns the state machine to IDLE.
  - Any partial pulse is discarded and no record is emitted for it.
- An input beat is accepted when s_tvalid & s_tready.
- s_tready = ~m_tvalid | m_tready. This is a one-entry output register, so input stalls only while a record is pending and not yet taken.
- State IDLE:
  - Accepted beat with s_tuser[0]=1 and enable=1 -> go to IN_PULSE.
  - On that transition: width <= 1, peak <= s_tdata, sat <= 0.
  - s_tuser[1] alone is ignored.
  - If both flag bits are set, rising wins.
- State IN_PULSE, accepted beat with s_tuser[1]=1:
  - Pulse ends; the falling beat is not counted and not used for the peak.
  - Load the output register: m_tdata <= {peak, width}, m_tuser <= sat, m_tvalid <= 1.
  - Go to IDLE.
  - If both flag bits are set, falling wins.
  - A rising flag alone in IN_PULSE is ignored: the beat is treated as an ordinary in-pulse sample.
- State IN_PULSE, any other accepted beat:
  - If width == 2^CNT_WIDTH-1, width holds and sat <= 1; otherwise width <= width+1.
  - peak <= max(peak, s_tdata), using a signed compare.
- Latency: m_tvalid rises on the clock edge that accepts the falling beat. The record is visible in the following cycle.
- Output handshake:
  - m_tdata and m_tuser are held stable while m_tvalid=1 and m_tready=0.
  - On m_tvalid & m_tready: pulse_count <= pulse_count+1.
  - m_tvalid clears unless a new record loads in the same cycle.
- Same-cycle load: a falling beat may be accepted in the same cycle the old record is taken (s_tready=1 via m_tready). The new record replaces the old one with m_tvalid staying 1, and pulse_count still increments once.
- Zero-length pulse: not possible, because the rising beat always counts as 1. Rising followed immediately by falling gives width=1, peak = the rising sample.
- enable deasserted mid-pulse does not abort the pulse.
- No input beats are dropped. Back-pressure always propagates to s_tready.

Test Plan:
- WIDTH=16, CNT_WIDTH=8, m_tready=1. Beats (data/tuser): 100/01, 200/00, 300/00, 250/00, 50/10 -> one record, width=4, peak=300, m_tuser=0, m_tvalid high the cycle after the falling beat, pulse_count=1.
- Signed peak. Beats: -500/01, -400/00, -450/00, -600/10 -> width=3, peak=-400 (0xFE70).
- Back-pressure:
  - Complete a pulse with m_tready=0 -> s_tready=0 next cycle, record stable for 10 cycles, pulse_count unchanged.
  - Raise m_tready -> one transfer, pulse_count increments.
  - Following pulse back-to-back with m_tready=1 -> record replaced with m_tvalid continuously high.
- Saturation: rising beat plus 299 in-pulse beats, then falling -> width=255, m_tuser=1. The next short pulse of width 2 reports m_tuser=0.
- Reset mid-pulse: rising 100, in-pulse 400, assert reset for 1 cycle, then pulse 10/01, 20/00, 5/10 -> only one record, width=2, peak=20, pulse_count=1.
- Gating:
  - enable=0 with rising flags -> no record; a falling flag in IDLE -> no record.
  - enable dropped after a rising beat -> the pulse still completes and reports correctly.
